fifo_sync_32x512: RTL and testbench
===================================

Name: fifo_sync_32x512

Overview:
- Single-clock, standard-read-mode (non-FWFT) FIFO, 32 bits wide and 512 words deep, with full, almost-full, empty and almost-empty flags.
- Sits between the host-message write stream and the application's message consumer.
- Also usable as a loopback buffer that echoes host messages back to the read channel.
- Storage is an inferred block RAM.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 512, number of storable words; power of two, at least 4.
- AFULL_MARGIN, 1, almost_full asserts when the stored word count is at least DEPTH-AFULL_MARGIN.
- AEMPTY_MARGIN, 1, almost_empty asserts when the stored word count is at most AEMPTY_MARGIN.

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  asynchronous, active-low reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data, registered.
- full  out  1  FIFO holds DEPTH words.
- almost_full  out  1  count >= DEPTH-AFULL_MARGIN.
- empty  out  1  FIFO holds 0 words.
- almost_empty  out  1  count <= AEMPTY_MARGIN.

Behaviour:
- Reset (RESET low, asynchronous assert, release synchronous to CLK):
  - write pointer, read pointer and count go to 0.
  - dout=0, empty=1, almost_empty=1, full=0, almost_full=0.
  - Reset mid-operation discards all contents; RAM contents are don't-care.
- Write acceptance:
  - A write is accepted on a rising edge when wr_en=1 and full=0.
  - The accepted din is stored at the write pointer, which increments modulo DEPTH.
  - wr_en while full is ignored silently: no pointer change and no data corruption.
- Read acceptance:
  - A read is accepted when rd_en=1 and empty=0.
  - The word at the read pointer appears on dout after the same edge, so it is valid from the next cycle (1-cycle latency, standard mode).
  - The read pointer then increments modulo DEPTH.
  - rd_en while empty is ignored; dout holds its previous value.
  - dout also holds its value whenever no read is accepted.
- Flag evaluation: acceptance of each request is judged against the flags registered before the edge.
  - Simultaneous read and write while full: only the read is accepted; count decrements.
  - Simultaneous read and write while empty: only the write is accepted; count increments.
  - Simultaneous read and write otherwise: both are accepted; count is unchanged and flags are unchanged.
- Count: log2(DEPTH)+1 bits wide, so 0..DEPTH inclusive is representable; pointers are log2(DEPTH) bits and wrap naturally.
- Flags are all registered and update in the same edge as the count: full=(count==DEPTH), empty=(count==0), plus the almost thresholds above.
- Write-to-read visibility:
  - A word written at edge N causes empty to deassert after edge N.
  - It may be read with rd_en at edge N+1 and is on dout after edge N+1.
- RAM read is synchronous and dout is the RAM output register. No read-during-write hazard exists, because a location is never read and written in the same cycle while count>0.

Optional Feature:
- Macro FIFO_DATA_COUNT_EN.
- When defined: adds an output port data_count, log2(DEPTH)+1 bits wide, equal to the registered internal count. It is reset to 0 and updated on the same edge as the flags.
- When undefined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_WIDTH_DEF=32 and FIFO_DEPTH_DEF=512 constants.
  - A clog2 function.
  - A count typedef sized log2(DEPTH)+1 for the default configuration.
- One sub-module fifo_sdp_ram: simple dual-port RAM, WIDTH x DEPTH, one write port (we, waddr, wdata), one synchronous read port (re, raddr, rdata registered, output held when re=0).
- Control logic (pointers, count, flags) stays in the top module.

Test Plan:
- Reset then idle: hold RESET low 3 cycles and release -> empty=1, almost_empty=1, full=0, almost_full=0, dout=0; rd_en=1 for 2 cycles -> nothing changes.
- Single word: write 'h3C23_D70A -> empty=0 the next cycle, almost_empty=1; rd_en one cycle later -> dout='h3C23_D70A one cycle after, empty=1.
- Ordering: write 'h0000_0140, 'h0012_0000, 'h3C23_D70A back-to-back, then read 3 -> the same order on dout; almost_empty deasserts after the 2nd write.
- Fill to full:
  - Write 512 incrementing words -> almost_full after the 511th write, full after the 512th.
  - A 513th write of 'hDEAD_BEEF is ignored.
  - Read all 512 -> values 0..511, with no 'hDEAD_BEEF.
- Simultaneous read/write:
  - At count 5 -> count stays 5 and order is preserved.
  - At full -> only the read is accepted; full=0 afterwards.
  - At empty -> only the write is accepted; empty=0 afterwards.
- Async reset mid-stream: with 100 words stored, pulse RESET low between edges -> flags return to reset values immediately, without waiting for an edge; subsequent write/read of 'h0000_0940 is returned correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, helper function and count type for the synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 512;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int FIFO_CNT_W_DEF = clog2(FIFO_DEPTH_DEF) + 1;

  typedef logic [FIFO_CNT_W_DEF-1:0] fifo_count_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose
// output register holds its value when no read is requested.
module fifo_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_32x512.sv
// Single-clock standard-mode FIFO with registered full/empty/almost flags.
// Define FIFO_DATA_COUNT_EN to expose the internal word count as data_count.
module fifo_sync_32x512
  import fifo_pkg::*;
#(
  parameter int WIDTH         = FIFO_WIDTH_DEF,
  parameter int DEPTH         = FIFO_DEPTH_DEF,
  parameter int AFULL_MARGIN  = 1,
  parameter int AEMPTY_MARGIN = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty
`ifdef FIFO_DATA_COUNT_EN
  ,
  output logic [clog2(DEPTH):0] data_count
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_full;
  logic          r_almost_full;
  logic          r_empty;
  logic          r_almost_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Acceptance uses the flags registered before the edge.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count        <= w_count_next;
      r_full         <= (w_count_next == CW'(DEPTH));
      r_almost_full  <= (w_count_next >= CW'(DEPTH - AFULL_MARGIN));
      r_empty        <= (w_count_next == '0);
      r_almost_empty <= (w_count_next <= CW'(AEMPTY_MARGIN));
    end
  end

  fifo_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RESET),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata (din),
    .re    (w_rd_acc),
    .raddr (r_rd_ptr),
    .rdata (dout)
  );

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;

`ifdef FIFO_DATA_COUNT_EN
  assign data_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_sync_32x512.sv
// Self-checking bench for fifo_sync_32x512 against a queue-based reference model.
module tb_fifo_sync_32x512;

  localparam int DEPTH = 512;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] din = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] dout;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic        almost_empty;
`ifdef FIFO_DATA_COUNT_EN
  logic [9:0]  data_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$];
  logic [31:0] model_dout = '0;

  always #5 CLK = ~CLK;

  fifo_sync_32x512 dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty)
`ifdef FIFO_DATA_COUNT_EN
    ,
    .data_count   (data_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".dout"},   dout,                 model_dout);
    check({tag, ".empty"},  {31'b0, empty},        {31'b0, n == 0});
    check({tag, ".aempty"}, {31'b0, almost_empty}, {31'b0, n <= 1});
    check({tag, ".full"},   {31'b0, full},         {31'b0, n == DEPTH});
    check({tag, ".afull"},  {31'b0, almost_full},  {31'b0, n >= DEPTH - 1});
`ifdef FIFO_DATA_COUNT_EN
    check({tag, ".count"},  {22'b0, data_count},   32'(n));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic cycle(input string tag, input logic wr, input logic rd, input logic [31:0] d);
    bit wa;
    bit ra;
    @(negedge CLK);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    wa = wr && (model_q.size() < DEPTH);
    ra = rd && (model_q.size() > 0);
    @(posedge CLK);
    if (ra) model_dout = model_q.pop_front();
    if (wa) model_q.push_back(d);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RESET = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (cycles) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    model_q.delete();
    model_dout = '0;
    #1;
    check_state("reset");
  endtask

  initial begin
    // Reset then idle reads on an empty FIFO
    do_reset(3);
    cycle("idle_rd", 1'b0, 1'b1, 32'h0);
    cycle("idle_rd", 1'b0, 1'b1, 32'h0);
    check("idle_dout", dout, 32'h0);

    // Single word
    cycle("single_wr", 1'b1, 1'b0, 32'h3C23_D70A);
    check("single_empty", {31'b0, empty}, 32'd0);
    check("single_aempty", {31'b0, almost_empty}, 32'd1);
    cycle("single_rd", 1'b0, 1'b1, 32'h0);
    check("single_dout", dout, 32'h3C23_D70A);
    cycle("single_idle", 1'b0, 1'b0, 32'h0);

    // Ordering
    cycle("ord_wr", 1'b1, 1'b0, 32'h0000_0140);
    cycle("ord_wr", 1'b1, 1'b0, 32'h0012_0000);
    check("ord_aempty_2", {31'b0, almost_empty}, 32'd0);
    cycle("ord_wr", 1'b1, 1'b0, 32'h3C23_D70A);
    cycle("ord_rd", 1'b0, 1'b1, 32'h0);
    check("ord_d0", dout, 32'h0000_0140);
    cycle("ord_rd", 1'b0, 1'b1, 32'h0);
    check("ord_d1", dout, 32'h0012_0000);
    cycle("ord_rd", 1'b0, 1'b1, 32'h0);
    check("ord_d2", dout, 32'h3C23_D70A);

    // Fill to full, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill_wr", 1'b1, 1'b0, 32'(i));
      if (i == DEPTH - 2) begin
        check("fill_afull_511", {31'b0, almost_full}, 32'd1);
        check("fill_full_511", {31'b0, full}, 32'd0);
      end
    end
    check("fill_full_512", {31'b0, full}, 32'd1);
    cycle("ovf_wr", 1'b1, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < DEPTH; i++) begin
      cycle("drain_rd", 1'b0, 1'b1, 32'h0);
      check("drain_val", dout, 32'(i));
    end
    check("drain_empty", {31'b0, empty}, 32'd1);

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) cycle("c5_wr", 1'b1, 1'b0, 32'h100 + 32'(i));
    cycle("c5_rw", 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 5; i++) cycle("c5_rd", 1'b0, 1'b1, 32'h0);

    // Simultaneous read/write at full
    for (int i = 0; i < DEPTH - model_q.size(); ) cycle("f_wr", 1'b1, 1'b0, $urandom);
    check("f_full", {31'b0, full}, 32'd1);
    cycle("f_rw", 1'b1, 1'b1, 32'hCAFE_F00D);
    check("f_rw_full", {31'b0, full}, 32'd0);
    while (model_q.size() > 0) cycle("f_rd", 1'b0, 1'b1, 32'h0);

    // Simultaneous read/write at empty
    cycle("e_rw", 1'b1, 1'b1, 32'h1234_5678);
    check("e_rw_empty", {31'b0, empty}, 32'd0);
    cycle("e_rd", 1'b0, 1'b1, 32'h0);

    // Randomized traffic with alternating write-heavy and read-heavy phases
    for (int i = 0; i < 1500; i++) begin
      int pw;
      pw = ((i % 600) < 300) ? 80 : 25;
      cycle("rand", ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < 50), $urandom);
    end

    // Asynchronous reset mid-stream with 100 words stored
    while (model_q.size() > 0) cycle("pre_rst_rd", 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 100; i++) cycle("mid_wr", 1'b1, 1'b0, $urandom);
    @(negedge CLK);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    RESET = 1'b0;
    model_q.delete();
    model_dout = '0;
    #1;
    check_state("async_rst");
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_state("rst_release");
    cycle("post_wr", 1'b1, 1'b0, 32'h0000_0940);
    cycle("post_rd", 1'b0, 1'b1, 32'h0);
    check("post_dout", dout, 32'h0000_0940);
    cycle("post_idle", 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time bound so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
